// File: rtl/id_pkg.sv
// id_pkg: shared encodings and control decode for the ARM-subset decode stage
package id_pkg;
  localparam logic [1:0] MODE_ALU = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10;
  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
                         OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
                         OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0000, CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011,
                         CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110, CMD_ORR = 4'b0111,
                         CMD_EOR = 4'b1000, CMD_MVN = 4'b1001;
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                         COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;
  // rd_ops marks recognised ALU/memory ops that read operands and honour the I bit
  typedef struct packed {
    logic [3:0] cmd;
    logic       wb_en;
    logic       mem_r;
    logic       mem_w;
    logic       b;
    logic       s;
    logic       rd_ops;
    logic       has_src1;
  } ctrl_t;
  function automatic ctrl_t ctrl_decode(input logic [1:0] mode, input logic [3:0] opcode, input logic s);
    ctrl_t c;
    c = '0;
    case (mode)
      MODE_ALU: begin
        case (opcode)
          OP_MOV: c.cmd = CMD_MOV;
          OP_MVN: c.cmd = CMD_MVN;
          OP_ADD: c.cmd = CMD_ADD;
          OP_ADC: c.cmd = CMD_ADC;
          OP_SUB: c.cmd = CMD_SUB;
          OP_SBC: c.cmd = CMD_SBC;
          OP_AND: c.cmd = CMD_AND;
          OP_ORR: c.cmd = CMD_ORR;
          OP_EOR: c.cmd = CMD_EOR;
          OP_CMP: c.cmd = CMD_SUB;
          OP_TST: c.cmd = CMD_AND;
          default: c.cmd = CMD_NOP;
        endcase
        if (c.cmd != CMD_NOP) begin
          c.wb_en    = (opcode != OP_CMP) && (opcode != OP_TST);
          c.s        = s;
          c.rd_ops   = 1'b1;
          c.has_src1 = (opcode != OP_MOV) && (opcode != OP_MVN);
        end
      end
      MODE_MEM: begin
        c.cmd      = CMD_ADD;
        c.mem_r    = s;
        c.mem_w    = ~s;
        c.wb_en    = s;
        c.rd_ops   = 1'b1;
        c.has_src1 = 1'b1;
      end
      MODE_BR: c.b = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/id_cond_eval.sv
// id_cond_eval: ARM condition code check against {N,Z,C,V}
module id_cond_eval
  import id_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = status;
  // standard ARM condition table; NV never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: decode, operand read, hazard stall and registered ID/EX boundary
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int NUM_HAZ        = 2,
  parameter int BYPASS_WB      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              if_valid,
  output logic                              id_ready,
  input  logic [WORD_WIDTH-1:0]             pc_in,
  input  logic [WORD_WIDTH-1:0]             instr_in,
  input  logic [3:0]                        status,
  input  logic                              flush,
  output logic [REG_ADDR_WIDTH-1:0]         rf_src1,
  output logic [REG_ADDR_WIDTH-1:0]         rf_src2,
  input  logic [WORD_WIDTH-1:0]             rf_data1,
  input  logic [WORD_WIDTH-1:0]             rf_data2,
  input  logic                              wb_en,
  input  logic [REG_ADDR_WIDTH-1:0]         wb_addr,
  input  logic [WORD_WIDTH-1:0]             wb_data,
  input  logic [NUM_HAZ-1:0]                haz_wb_en,
  input  logic [NUM_HAZ*REG_ADDR_WIDTH-1:0] haz_dst,
  input  logic                              ex_ready,
  output logic                              ex_valid,
  output logic [WORD_WIDTH-1:0]             ex_pc,
  output logic [WORD_WIDTH-1:0]             ex_val_rn,
  output logic [WORD_WIDTH-1:0]             ex_val_rm,
  output logic [REG_ADDR_WIDTH-1:0]         ex_dst,
  output logic [REG_ADDR_WIDTH-1:0]         ex_src1,
  output logic [REG_ADDR_WIDTH-1:0]         ex_src2,
  output logic [11:0]                       ex_shift_op,
  output logic [23:0]                       ex_simm,
  output logic [3:0]                        ex_cmd,
  output logic                              ex_mem_r,
  output logic                              ex_mem_w,
  output logic                              ex_wb_en,
  output logic                              ex_b,
  output logic                              ex_s,
  output logic                              ex_imm
);
  localparam int RAW = REG_ADDR_WIDTH;
  ctrl_t ctrl;
  logic pass, imm, has_src2, hz, hazard, adv;
  logic [RAW-1:0] rn, rd, rm;
  logic [WORD_WIDTH-1:0] op1, op2;
  assign rn = RAW'(instr_in[19:16]);
  assign rd = RAW'(instr_in[15:12]);
  assign rm = RAW'(instr_in[3:0]);
  assign ctrl = ctrl_decode(instr_in[27:26], instr_in[24:21], instr_in[20]);
  assign imm = ctrl.rd_ops & instr_in[25];
  assign has_src2 = ctrl.rd_ops & (~instr_in[25] | ctrl.mem_w);
  assign rf_src1 = rn;
  assign rf_src2 = ctrl.mem_w ? rd : rm;
  assign op1 = (BYPASS_WB != 0 && wb_en && wb_addr == rf_src1) ? wb_data : rf_data1;
  assign op2 = (BYPASS_WB != 0 && wb_en && wb_addr == rf_src2) ? wb_data : rf_data2;
  id_cond_eval u_cond (
    .cond  (instr_in[31:28]),
    .status(status),
    .pass  (pass)
  );
  // RAW check against every downstream destination, on the raw decode so failed conditions still stall
  always_comb begin
    hz = 1'b0;
    for (int k = 0; k < NUM_HAZ; k++)
      hz = hz | (haz_wb_en[k] & ((ctrl.has_src1 & (rn == haz_dst[k*RAW+:RAW])) |
                                 (has_src2 & (rf_src2 == haz_dst[k*RAW+:RAW]))));
  end
  assign hazard = if_valid & hz;
  assign adv = ~ex_valid | ex_ready;
  assign id_ready = flush | (adv & ~hazard);
  // ID/EX register: flush drops, hazard bubbles, backpressure holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_val_rn   <= '0;
      ex_val_rm   <= '0;
      ex_dst      <= '0;
      ex_src1     <= '0;
      ex_src2     <= '0;
      ex_shift_op <= '0;
      ex_simm     <= '0;
      ex_cmd      <= '0;
      ex_mem_r    <= 1'b0;
      ex_mem_w    <= 1'b0;
      ex_wb_en    <= 1'b0;
      ex_b        <= 1'b0;
      ex_s        <= 1'b0;
      ex_imm      <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      ex_valid    <= if_valid & ~hazard;
      ex_pc       <= pc_in;
      ex_val_rn   <= op1;
      ex_val_rm   <= op2;
      ex_dst      <= rd;
      ex_src1     <= rf_src1;
      ex_src2     <= rf_src2;
      ex_shift_op <= instr_in[11:0];
      ex_simm     <= instr_in[23:0];
      ex_cmd      <= pass ? ctrl.cmd : CMD_NOP;
      ex_mem_r    <= pass & ctrl.mem_r;
      ex_mem_w    <= pass & ctrl.mem_w;
      ex_wb_en    <= pass & ctrl.wb_en;
      ex_b        <= pass & ctrl.b;
      ex_s        <= pass & ctrl.s;
      ex_imm      <= imm;
    end
  end
endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: directed vector table plus stall/flush/reset sequences
module tb_id_stage_pipelined;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic        id_ready;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic [3:0]  status = '0;
  logic        flush = 1'b0;
  logic [3:0]  rf_src1, rf_src2;
  logic [31:0] rf_data1, rf_data2;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [1:0]  haz_wb_en = '0;
  logic [7:0]  haz_dst = '0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [3:0]  ex_dst, ex_src1, ex_src2;
  logic [11:0] ex_shift_op;
  logic [23:0] ex_simm;
  logic [3:0]  ex_cmd;
  logic        ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s, ex_imm;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign rf_data1 = 32'hA000_0000 | {28'b0, rf_src1};
  assign rf_data2 = 32'hA000_0000 | {28'b0, rf_src2};
  id_stage_pipelined dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .id_ready(id_ready), .pc_in(pc_in),
    .instr_in(instr_in), .status(status), .flush(flush), .rf_src1(rf_src1), .rf_src2(rf_src2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .haz_wb_en(haz_wb_en), .haz_dst(haz_dst), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_dst(ex_dst),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_shift_op(ex_shift_op), .ex_simm(ex_simm),
    .ex_cmd(ex_cmd), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w), .ex_wb_en(ex_wb_en),
    .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm)
  );
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  st;
    logic        wbe;
    logic [3:0]  wba;
    logic [31:0] wbd;
    logic [3:0]  src2;
    logic [3:0]  cmd;
    logic        wb, mr, mw, b, s, imm;
    logic [3:0]  dst;
    logic [31:0] rn, rm;
  } vec_t;
  vec_t vec [14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    instr_in = instr;
    pc_in = pc;
  endtask
  initial begin
    vec[0]  = '{32'hE0821003, 4'h0, 1'b0, 4'h0, 32'h0, 4'd3, 4'h2, 1, 0, 0, 0, 0, 0, 4'd1, 32'hA0000002, 32'hA0000003};
    vec[1]  = '{32'h00821003, 4'h0, 1'b0, 4'h0, 32'h0, 4'd3, 4'h0, 0, 0, 0, 0, 0, 0, 4'd1, 32'hA0000002, 32'hA0000003};
    vec[2]  = '{32'h00821003, 4'h4, 1'b0, 4'h0, 32'h0, 4'd3, 4'h2, 1, 0, 0, 0, 0, 0, 4'd1, 32'hA0000002, 32'hA0000003};
    vec[3]  = '{32'hE5821004, 4'h0, 1'b1, 4'h1, 32'h0000DEAD, 4'd1, 4'h2, 0, 0, 1, 0, 0, 0, 4'd1, 32'hA0000002, 32'h0000DEAD};
    vec[4]  = '{32'hE5921004, 4'h0, 1'b0, 4'h0, 32'h0, 4'd4, 4'h2, 1, 1, 0, 0, 0, 0, 4'd1, 32'hA0000002, 32'hA0000004};
    vec[5]  = '{32'hE0565007, 4'h0, 1'b0, 4'h0, 32'h0, 4'd7, 4'h4, 1, 0, 0, 0, 1, 0, 4'd5, 32'hA0000006, 32'hA0000007};
    vec[6]  = '{32'hE1510002, 4'h0, 1'b0, 4'h0, 32'h0, 4'd2, 4'h4, 0, 0, 0, 0, 1, 0, 4'd0, 32'hA0000001, 32'hA0000002};
    vec[7]  = '{32'hE3A03005, 4'h0, 1'b0, 4'h0, 32'h0, 4'd5, 4'h1, 1, 0, 0, 0, 0, 1, 4'd3, 32'hA0000000, 32'hA0000005};
    vec[8]  = '{32'hEA000010, 4'h0, 1'b0, 4'h0, 32'h0, 4'd0, 4'h0, 0, 0, 0, 1, 0, 0, 4'd0, 32'hA0000000, 32'hA0000000};
    vec[9]  = '{32'hE0621003, 4'h0, 1'b0, 4'h0, 32'h0, 4'd3, 4'h0, 0, 0, 0, 0, 0, 0, 4'd1, 32'hA0000002, 32'hA0000003};
    vec[10] = '{32'hE1821003, 4'h0, 1'b0, 4'h0, 32'h0, 4'd3, 4'h7, 1, 0, 0, 0, 0, 0, 4'd1, 32'hA0000002, 32'hA0000003};
    vec[11] = '{32'hE0821003, 4'h0, 1'b1, 4'h2, 32'h12345678, 4'd3, 4'h2, 1, 0, 0, 0, 0, 0, 4'd1, 32'h12345678, 32'hA0000003};
    vec[12] = '{32'hB0565007, 4'h0, 1'b0, 4'h0, 32'h0, 4'd7, 4'h0, 0, 0, 0, 0, 0, 0, 4'd5, 32'hA0000006, 32'hA0000007};
    vec[13] = '{32'hB0565007, 4'h8, 1'b0, 4'h0, 32'h0, 4'd7, 4'h4, 1, 0, 0, 0, 1, 0, 4'd5, 32'hA0000006, 32'hA0000007};
    #2;
    chk("reset_valid", {31'b0, ex_valid}, 32'h0);
    step();
    step();
    chk("reset_payload", ex_val_rn | ex_val_rm | ex_pc | {28'b0, ex_cmd} | {28'b0, ex_dst}, 32'h0);
    chk("reset_ctrl", {26'b0, ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s, ex_imm}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      present(vec[i].instr, 32'h100 + 32'(i) * 4);
      status = vec[i].st;
      wb_en = vec[i].wbe;
      wb_addr = vec[i].wba;
      wb_data = vec[i].wbd;
      #2;
      chk($sformatf("v%0d_rf_src2", i), {28'b0, rf_src2}, {28'b0, vec[i].src2});
      chk($sformatf("v%0d_id_ready", i), {31'b0, id_ready}, 32'h1);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, 32'h1);
      chk($sformatf("v%0d_ctrl", i), {22'b0, ex_cmd, ex_wb_en, ex_mem_r, ex_mem_w, ex_b, ex_s, ex_imm},
          {22'b0, vec[i].cmd, vec[i].wb, vec[i].mr, vec[i].mw, vec[i].b, vec[i].s, vec[i].imm});
      chk($sformatf("v%0d_dst", i), {28'b0, ex_dst}, {28'b0, vec[i].dst});
      chk($sformatf("v%0d_rn", i), ex_val_rn, vec[i].rn);
      chk($sformatf("v%0d_rm", i), ex_val_rm, vec[i].rm);
      chk($sformatf("v%0d_pc", i), ex_pc, 32'h100 + 32'(i) * 4);
    end
    wb_en = 1'b0;
    status = 4'h0;
    present(32'hE0821003, 32'h200);
    haz_wb_en = 2'b01;
    haz_dst = {4'd0, 4'd2};
    #2;
    chk("haz_rn_ready", {31'b0, id_ready}, 32'h0);
    step();
    chk("haz_rn_bubble", {31'b0, ex_valid}, 32'h0);
    haz_wb_en = 2'b10;
    haz_dst = {4'd3, 4'd0};
    #2;
    chk("haz_rm_ready", {31'b0, id_ready}, 32'h0);
    step();
    chk("haz_rm_bubble", {31'b0, ex_valid}, 32'h0);
    haz_wb_en = 2'b00;
    #2;
    chk("haz_clear_ready", {31'b0, id_ready}, 32'h1);
    step();
    chk("haz_clear_valid", {31'b0, ex_valid}, 32'h1);
    chk("haz_clear_cmd", {28'b0, ex_cmd}, 32'h2);
    chk("haz_clear_pc", ex_pc, 32'h200);
    present(32'hE3A03005, 32'h204);
    haz_wb_en = 2'b11;
    haz_dst = {4'd5, 4'd0};
    #2;
    chk("haz_mov_imm_ready", {31'b0, id_ready}, 32'h1);
    step();
    chk("haz_mov_imm_valid", {31'b0, ex_valid}, 32'h1);
    haz_wb_en = 2'b00;
    present(32'hE0821003, 32'h300);
    step();
    chk("bp_issue", {31'b0, ex_valid}, 32'h1);
    ex_ready = 1'b0;
    present(32'hE0565007, 32'h304);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("bp%0d_ready", c), {31'b0, id_ready}, 32'h0);
      step();
      chk($sformatf("bp%0d_hold", c), {ex_pc[15:0], 3'b0, ex_valid, ex_dst, ex_cmd, ex_s}, {16'h0300, 3'b0, 1'b1, 4'd1, 4'h2, 1'b0});
      chk($sformatf("bp%0d_rn", c), ex_val_rn, 32'hA0000002);
    end
    flush = 1'b1;
    #2;
    chk("flush_ready", {31'b0, id_ready}, 32'h1);
    step();
    chk("flush_valid", {31'b0, ex_valid}, 32'h0);
    flush = 1'b0;
    ex_ready = 1'b1;
    present(32'hE0821003, 32'h400);
    step();
    chk("rst_setup_valid", {31'b0, ex_valid}, 32'h1);
    ex_ready = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_async_payload", ex_val_rn | ex_val_rm | ex_pc | {28'b0, ex_cmd} | {28'b0, ex_dst}, 32'h0);
    chk("rst_async_ctrl", {27'b0, ex_mem_r, ex_mem_w, ex_wb_en, ex_b, ex_s}, 32'h0);
    step();
    rst = 1'b1;
    ex_ready = 1'b1;
    present(32'hE0565007, 32'h500);
    step();
    chk("post_rst_valid", {31'b0, ex_valid}, 32'h1);
    chk("post_rst_dst", {28'b0, ex_dst}, 32'h5);
    chk("post_rst_pc", ex_pc, 32'h500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
